// File: rtl/roll_scheduler_if.sv
// rtl/roll_scheduler_if.sv - RNG byte and roll result handshakes for roll_scheduler
// The slave modport is the scheduler; master is the RNG/UART side.
interface roll_scheduler_if #(
    parameter int SUM_W = 8
);
    logic             i_rand_valid;
    logic [7:0]       i_rand_data;
    logic             o_rand_ready;
    logic             o_roll_valid;
    logic [SUM_W-1:0] o_roll_sum;
    logic [4:0]       o_last_die;
    logic             o_err;
    logic             i_roll_ready;
    logic             o_stop;

    modport slave (
        input  i_rand_valid, i_rand_data, i_roll_ready,
        output o_rand_ready, o_roll_valid, o_roll_sum, o_last_die, o_err, o_stop
    );

    modport master (
        output i_rand_valid, i_rand_data, i_roll_ready,
        input  o_rand_ready, o_roll_valid, o_roll_sum, o_last_die, o_err, o_stop
    );
endinterface

// File: rtl/roll_scheduler.sv
// rtl/roll_scheduler.sv - multi-die roll sequencer, mask-and-reject face mapping
// Optional DICE_ADVANTAGE_EN: i_adv takes the larger of two accepted values per die.
module roll_scheduler #(
    parameter int MAX_DICE  = 8,
    parameter int MAX_RETRY = 16,
    parameter int SUM_W     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [2:0] i_die_sel,
    input  logic [3:0] i_count,
`ifdef DICE_ADVANTAGE_EN
    input  logic       i_adv,
`endif
    output logic       o_busy,
    roll_scheduler_if.slave bus
);
    localparam int RTW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_OUTPUT} state_t;

    state_t           r_state, w_next;
    logic [2:0]       r_die_sel;
    logic [3:0]       r_remaining;
    logic [RTW-1:0]   r_retry;
    logic [7:0]       r_v;
    logic [SUM_W-1:0] r_sum;
    logic [4:0]       r_last;
    logic             r_err;
    logic             r_stop;
`ifdef DICE_ADVANTAGE_EN
    logic             r_adv;
    logic             r_first_done;
    logic [4:0]       r_first_val;
`endif

    logic [7:0]     w_n, w_m;
    logic           w_sel_ok;
    logic [3:0]     w_count;
    logic           w_accept;
    logic [4:0]     w_face;
    logic [RTW-1:0] w_retry_inc;
    logic           w_retry_max;
    logic           w_die_done;
    logic [4:0]     w_die_val;
    logic           w_final;

    always_comb begin
        w_n = 8'd0;
        w_m = 8'd0;
        case (r_die_sel)
            3'd0: begin w_n = 8'd4;  w_m = 8'd3;  end
            3'd1: begin w_n = 8'd6;  w_m = 8'd7;  end
            3'd2: begin w_n = 8'd8;  w_m = 8'd7;  end
            3'd3: begin w_n = 8'd10; w_m = 8'd15; end
            3'd4: begin w_n = 8'd12; w_m = 8'd15; end
            3'd5: begin w_n = 8'd20; w_m = 8'd31; end
            default: begin w_n = 8'd0; w_m = 8'd0; end
        endcase
    end

    always_comb begin
        w_count = i_count;
        if (i_count == 4'd0)
            w_count = 4'd1;
        else if (32'(i_count) > MAX_DICE)
            w_count = 4'(MAX_DICE);
    end

    assign w_sel_ok    = (i_die_sel <= 3'd5);
    assign w_accept    = (r_v < w_n);
    assign w_face      = r_v[4:0] + 5'd1;
    assign w_retry_inc = r_retry + RTW'(1);
    assign w_retry_max = (w_retry_inc == RTW'(MAX_RETRY));

`ifdef DICE_ADVANTAGE_EN
    // First accepted value of an advantage die is parked; the second decides the die.
    assign w_die_done = !r_adv || r_first_done;
    assign w_die_val  = (r_first_done && (r_first_val > w_face)) ? r_first_val : w_face;
`else
    assign w_die_done = 1'b1;
    assign w_die_val  = w_face;
`endif

    assign w_final = w_accept && w_die_done && (r_remaining == 4'd1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = w_sel_ok ? S_FETCH : S_OUTPUT;
            S_FETCH:  if (bus.i_rand_valid) w_next = S_CHECK;
            S_CHECK: begin
                if (w_accept)
                    w_next = w_final ? S_OUTPUT : S_FETCH;
                else
                    w_next = w_retry_max ? S_OUTPUT : S_FETCH;
            end
            S_OUTPUT: if (bus.i_roll_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_die_sel    <= 3'd0;
            r_remaining  <= 4'd0;
            r_retry      <= '0;
            r_v          <= 8'd0;
            r_sum        <= '0;
            r_last       <= 5'd0;
            r_err        <= 1'b0;
            r_stop       <= 1'b0;
`ifdef DICE_ADVANTAGE_EN
            r_adv        <= 1'b0;
            r_first_done <= 1'b0;
            r_first_val  <= 5'd0;
`endif
        end else begin
            r_stop <= (r_state == S_OUTPUT) && bus.i_roll_ready;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_die_sel   <= i_die_sel;
                        r_remaining <= w_count;
                        r_retry     <= '0;
                        r_sum       <= '0;
                        r_last      <= 5'd0;
                        r_err       <= !w_sel_ok;
`ifdef DICE_ADVANTAGE_EN
                        r_adv        <= i_adv;
                        r_first_done <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (bus.i_rand_valid)
                        r_v <= bus.i_rand_data & w_m;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_retry <= '0;
                        if (w_die_done) begin
                            r_sum       <= r_sum + SUM_W'(w_die_val);
                            r_last      <= w_die_val;
                            r_remaining <= r_remaining - 4'd1;
`ifdef DICE_ADVANTAGE_EN
                            r_first_done <= 1'b0;
`endif
                        end
`ifdef DICE_ADVANTAGE_EN
                        else begin
                            r_first_val  <= w_face;
                            r_first_done <= 1'b1;
                        end
`endif
                    end else begin
                        r_retry <= w_retry_inc;
                        if (w_retry_max)
                            r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy           = (r_state != S_IDLE);
    assign bus.o_rand_ready = (r_state == S_FETCH);
    assign bus.o_roll_valid = (r_state == S_OUTPUT);
    assign bus.o_roll_sum   = r_sum;
    assign bus.o_last_die   = r_last;
    assign bus.o_err        = r_err;
    assign bus.o_stop       = r_stop;
endmodule

// File: tb/tb_roll_scheduler.sv
// tb/tb_roll_scheduler.sv - directed self-checking bench for roll_scheduler
module tb_roll_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] die_sel;
    logic [3:0] count;
    logic       adv;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    roll_scheduler_if #(.SUM_W(8)) bus ();

    roll_scheduler #(.MAX_DICE(8), .MAX_RETRY(4), .SUM_W(8)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_die_sel (die_sel),
        .i_count   (count),
`ifdef DICE_ADVANTAGE_EN
        .i_adv     (adv),
`endif
        .o_busy    (busy),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_roll(input logic [2:0] s, input logic [3:0] c);
        @(negedge clk);
        start = 1'b1; die_sel = s; count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [7:0] b);
        int n = 0;
        while (!bus.o_rand_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk({tag, "_ready_timeout"}, 32'(bus.o_rand_ready), 32'd1);
        end else begin
            bus.i_rand_valid = 1'b1;
            bus.i_rand_data  = b;
            @(negedge clk);
            bus.i_rand_valid = 1'b0;
            bus.i_rand_data  = 8'hAA;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.o_roll_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.o_roll_valid), 32'd1);
    endtask

    task automatic finish_roll(input string tag);
        bus.i_roll_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_stop"}, 32'(bus.o_stop), 32'd1);
        chk({tag, "_valid_drop"}, 32'(bus.o_roll_valid), 32'd0);
        bus.i_roll_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; die_sel = 3'd0; count = 4'd0; adv = 1'b0;
        bus.i_rand_valid = 1'b0; bus.i_rand_data = 8'h00; bus.i_roll_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.o_rand_ready), 32'd0);
        chk("rst_valid", 32'(bus.o_roll_valid), 32'd0);
        chk("rst_sum", 32'(bus.o_roll_sum), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_stop", 32'(bus.o_stop), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // D6 x1, byte 0x2D -> face 6, RNG held valid to measure latency
        @(negedge clk);
        start = 1'b1; die_sel = 3'd1; count = 4'd1;
        bus.i_rand_valid = 1'b1; bus.i_rand_data = 8'h2D;
        @(negedge clk);
        start = 1'b0;
        chk("t1_rand_ready", 32'(bus.o_rand_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        bus.i_rand_valid = 1'b0;
        chk("t1_check_ready", 32'(bus.o_rand_ready), 32'd0);
        chk("t1_valid_early", 32'(bus.o_roll_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.o_roll_valid), 32'd1);
        chk("t1_sum", 32'(bus.o_roll_sum), 32'd6);
        chk("t1_last", 32'(bus.o_last_die), 32'd6);
        chk("t1_err", 32'(bus.o_err), 32'd0);
        finish_roll("t1");

        // D4 x3: 0x00->1, 0x03->4, 0x06->3
        start_roll(3'd0, 4'd3);
        feed("t2a", 8'h00); feed("t2b", 8'h03); feed("t2c", 8'h06);
        wait_valid("t2");
        chk("t2_sum", 32'(bus.o_roll_sum), 32'd8);
        chk("t2_last", 32'(bus.o_last_die), 32'd3);
        chk("t2_err", 32'(bus.o_err), 32'd0);
        finish_roll("t2");

        // D20 x1: 0x1F rejected, 0x13 -> 20
        start_roll(3'd5, 4'd1);
        feed("t3a", 8'h1F); feed("t3b", 8'h13);
        wait_valid("t3");
        chk("t3_sum", 32'(bus.o_roll_sum), 32'd20);
        chk("t3_last", 32'(bus.o_last_die), 32'd20);
        chk("t3_err", 32'(bus.o_err), 32'd0);
        finish_roll("t3");

        // Invalid selection goes straight to OUTPUT and holds
        start_roll(3'b110, 4'd2);
        chk("t4_valid", 32'(bus.o_roll_valid), 32'd1);
        chk("t4_ready", 32'(bus.o_rand_ready), 32'd0);
        chk("t4_err", 32'(bus.o_err), 32'd1);
        chk("t4_sum", 32'(bus.o_roll_sum), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(bus.o_roll_valid), 32'd1);
            chk("t4_hold_err", 32'(bus.o_err), 32'd1);
            chk("t4_hold_last", 32'(bus.o_last_die), 32'd0);
        end
        finish_roll("t4");
        @(negedge clk);
        chk("t4_stop_once", 32'(bus.o_stop), 32'd0);

        // D10, four rejects with MAX_RETRY=4 -> error, sum 0
        start_roll(3'd3, 4'd1);
        chk("t5_err_cleared", 32'(bus.o_err), 32'd0);
        for (int i = 0; i < 4; i++) feed("t5", 8'hFF);
        wait_valid("t5");
        chk("t5_err", 32'(bus.o_err), 32'd1);
        chk("t5_sum", 32'(bus.o_roll_sum), 32'd0);
        finish_roll("t5");

        // D10 x2: retry count resets after each accept; 0x01->2, 0x02->3
        start_roll(3'd3, 4'd2);
        for (int i = 0; i < 3; i++) feed("t6a", 8'hFF);
        feed("t6b", 8'h01);
        for (int i = 0; i < 3; i++) feed("t6c", 8'hFF);
        feed("t6d", 8'h02);
        wait_valid("t6");
        chk("t6_err", 32'(bus.o_err), 32'd0);
        chk("t6_sum", 32'(bus.o_roll_sum), 32'd5);
        chk("t6_last", 32'(bus.o_last_die), 32'd3);
        finish_roll("t6");

        // D10 x2: 0x09->10 then exhaustion keeps partial sum
        start_roll(3'd3, 4'd2);
        feed("t7a", 8'h09);
        for (int i = 0; i < 4; i++) feed("t7b", 8'hFF);
        wait_valid("t7");
        chk("t7_err", 32'(bus.o_err), 32'd1);
        chk("t7_sum", 32'(bus.o_roll_sum), 32'd10);
        chk("t7_last", 32'(bus.o_last_die), 32'd10);
        finish_roll("t7");

        // Count 0 acts as 1: D8, 0x07 -> 8
        start_roll(3'd2, 4'd0);
        feed("t8", 8'h07);
        wait_valid("t8");
        chk("t8_sum", 32'(bus.o_roll_sum), 32'd8);
        finish_roll("t8");

        // Count 15 saturates to 8: D4, eight 0x01 -> 2 each = 16
        start_roll(3'd0, 4'd15);
        for (int i = 0; i < 8; i++) feed("t9", 8'h01);
        @(negedge clk);
        chk("t9_valid", 32'(bus.o_roll_valid), 32'd1);
        chk("t9_sum", 32'(bus.o_roll_sum), 32'd16);
        chk("t9_last", 32'(bus.o_last_die), 32'd2);
        finish_roll("t9");

        // Reset during FETCH of a D6 x3 roll, then a clean D6 x2 roll
        start_roll(3'd1, 4'd3);
        feed("t10a", 8'h00);
        @(negedge clk);
        chk("t10_in_fetch", 32'(bus.o_rand_ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t10_rst_busy", 32'(busy), 32'd0);
        chk("t10_rst_ready", 32'(bus.o_rand_ready), 32'd0);
        chk("t10_rst_sum", 32'(bus.o_roll_sum), 32'd0);
        chk("t10_rst_last", 32'(bus.o_last_die), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_roll(3'd1, 4'd2);
        feed("t10b", 8'h00); feed("t10c", 8'h05);
        wait_valid("t10");
        chk("t10_sum", 32'(bus.o_roll_sum), 32'd7);
        chk("t10_last", 32'(bus.o_last_die), 32'd6);
        chk("t10_err", 32'(bus.o_err), 32'd0);
        finish_roll("t10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
- Sequences one complete multi-die roll.
- Accepts a roll request (die type and dice count) and pulls random bytes from the RNG over a valid/ready handshake.
- Maps each byte to a uniform face value 1..N by mask-and-reject, accumulates the sum, then presents the result to the UART/display side over a valid/ready handshake.
- Sits between the user-input decode, the RNG, and the UART interface.

Parameters:
- MAX_DICE, 8, maximum dice per request; larger i_count saturates to MAX_DICE.
- MAX_RETRY, 16, consecutive rejected bytes allowed per die before abort with error.
- SUM_W, 8, width of the accumulated sum (20*MAX_DICE must fit).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  request pulse; sampled only in IDLE
- i_die_sel  in  3  000=D4 001=D6 010=D8 011=D10 100=D12 101=D20; 110/111 invalid
- i_count  in  4  number of dice; 0 treated as 1
- o_busy  out  1  high in any state other than IDLE
- i_rand_valid  in  1  RNG byte available
- i_rand_data  in  8  RNG byte
- o_rand_ready  out  1  scheduler accepts RNG byte
- o_roll_valid  out  1  result available
- o_roll_sum  out  SUM_W  sum of all dice
- o_last_die  out  5  value of the final accepted die
- o_err  out  1  invalid selection or retry exhaustion; valid while o_roll_valid
- i_roll_ready  in  1  consumer accepts result
- o_stop  out  1  one-cycle pulse when the result handshake completes

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; internal sum, remaining count, retry count and latched selection cleared. Reset mid-roll aborts with no result.
- Faces N and mask M per die: D4 N=4 M=3; D6 N=6 M=7; D8 N=8 M=7; D10 N=10 M=15; D12 N=12 M=15; D20 N=20 M=31.
- States: IDLE, FETCH, CHECK, OUTPUT.
- IDLE: on i_start, latch i_die_sel and saturated/zero-fixed count; clear sum and retry count.
  - Valid selection -> FETCH.
  - Invalid selection -> OUTPUT with o_err=1, sum=0, last_die=0.
- FETCH: o_rand_ready=1. On i_rand_valid & o_rand_ready, register v = i_rand_data & M -> CHECK. While i_rand_valid=0, remain in FETCH.
- CHECK: o_rand_ready=0.
  - If v < N: sum += v+1; last_die = v+1; remaining -= 1; retry = 0. Then -> OUTPUT if remaining == 0, else -> FETCH.
  - Else (reject): retry += 1. If retry reaches MAX_RETRY: o_err=1 -> OUTPUT with the partial sum. Otherwise -> FETCH.
- OUTPUT: o_roll_valid=1. o_roll_sum, o_last_die and o_err are held stable until i_roll_ready. On handshake: -> IDLE, o_stop=1 for exactly that following cycle, and o_roll_valid drops.
- Latency: i_start to o_rand_ready = 1 cycle. Each byte costs 2 cycles (FETCH + CHECK) with RNG always valid. Last CHECK to o_roll_valid = 1 cycle.
- i_start outside IDLE is ignored.
- i_rand_data is ignored unless o_rand_ready is high.
- The sum never wraps within the stated parameter limits.
- o_err is cleared at the next accepted i_start.

Optional Feature:
- Macro: DICE_ADVANTAGE_EN.
- Defined: adds input port i_adv (1 bit), latched at start. When latched high, each die consumes two accepted values, and only the larger is added to the sum and reported in o_last_die. The retry count resets after each accepted value. With i_adv low, behaviour is identical to the base block.
- Undefined: the i_adv port does not exist; one accepted value per die.

Test Plan:
- D6, count 1, RNG byte 0x2D -> v=5 accepted; o_roll_sum=6, o_last_die=6, o_err=0; o_roll_valid 3 cycles after i_start.
- D4, count 3, bytes 0x00, 0x03, 0x06 -> o_roll_sum=1+4+3=8, o_last_die=3.
- D20, count 1, bytes 0x1F then 0x13 -> first rejected (31>=20), second accepted; o_roll_sum=20.
- i_die_sel=3'b110 -> o_rand_ready never asserted; o_roll_valid next cycle with o_err=1 and sum 0. Hold i_roll_ready low 5 cycles -> outputs stable; on ready, o_stop pulses 1 cycle.
- MAX_RETRY=4, D10, four bytes 0xFF (15>=10) -> o_err=1, o_roll_sum=0.
- Assert i_reset during FETCH of a 3-die roll -> outputs 0 immediately, state IDLE; a new i_start afterwards rolls correctly from sum 0.
